// File: rtl/step_pkg.sv
// ---------------------------------------------------------------------------
// step_pkg
//   Shared types and helpers for the step accumulator.
//   - state_t     : acceleration FSM states (IDLE, SLOW, FAST)
//   - dir_t       : latched step direction
//   - digit_count : number of decimal digits needed to show a value
// ---------------------------------------------------------------------------
package step_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SLOW = 2'd1,
      FAST = 2'd2
   } state_t;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_t;

   // Decimal digit count of a non-negative value (at least one digit).
   // The loop bound covers every 32-bit value.
   function automatic int digit_count(input int value);
      int n;
      int v;
      n = 1;
      v = value;
      for (int i = 0; i < 10; i++) begin
         if (v >= 10) begin
            v = v / 10;
            n++;
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/bin_to_bcd.sv
// ---------------------------------------------------------------------------
// bin_to_bcd
//   Combinational double-dabble converter.
//   Ports:
//     bin : binary input, W bits
//     bcd : packed BCD output, Digits nibbles, least significant digit in [3:0]
// ---------------------------------------------------------------------------
module bin_to_bcd #(
   parameter int W      = 14,
   parameter int Digits = 4
) (
   input  logic [W-1:0]        bin,
   output logic [4*Digits-1:0] bcd
);

   logic [4*Digits-1:0] acc;

   // NOTE: acc is assigned on every path before it is read, so no latch is
   // inferred even though it is updated repeatedly inside the loop.
   always_comb begin
      acc = '0;
      for (int i = W - 1; i >= 0; i--) begin
         // Any digit of 5 or more would overflow when doubled; pre-add 3.
         for (int d = 0; d < Digits; d++) begin
            if (acc[4*d +: 4] >= 4'd5) begin
               acc[4*d +: 4] = acc[4*d +: 4] + 4'd3;
            end
         end
         acc = {acc[4*Digits-2:0], bin[i]};
      end
   end

   assign bcd = acc;

endmodule

// File: rtl/step_accumulator.sv
// ---------------------------------------------------------------------------
// step_accumulator
//   Up/down value accumulator driven by single-cycle step strobes, with
//   acceleration: after FastThreshold same-direction pulses the step size
//   grows to FastStep. A quiet gap of GapCycles clocks drops back to idle.
//   The value either saturates or wraps at the range ends.
//   Ports:
//     Clock    : single clock, rising edge
//     nReset   : asynchronous active-low reset
//     iUp      : up step strobe (one cycle)
//     iDown    : down step strobe (one cycle)
//     oValue   : current value, binary, registered
//     oBcd     : oValue in BCD (combinational from the oValue register)
//     oChanged : one-cycle flag, oValue took a new value this cycle
//     oAtMin   : oValue == MinValue
//     oAtMax   : oValue == MaxValue
// ---------------------------------------------------------------------------
module step_accumulator
   import step_pkg::*;
#(
   parameter int ClockPeriod_ns  = 20,
   parameter int GapTimeout_ns   = 400_000_000,
   parameter int MinValue        = 0,
   parameter int MaxValue        = 9999,
   parameter int Wrap            = 0,
   parameter int FastThreshold   = 8,
   parameter int FastStep        = 10,
   localparam int W              = $clog2(MaxValue + 1),
   localparam int Digits         = digit_count(MaxValue)
) (
   input  logic                  Clock,
   input  logic                  nReset,
   input  logic                  iUp,
   input  logic                  iDown,
   output logic [W-1:0]          oValue,
   output logic [4*Digits-1:0]   oBcd,
   output logic                  oChanged,
   output logic                  oAtMin,
   output logic                  oAtMax
);

   localparam int GapCycles = GapTimeout_ns / ClockPeriod_ns;
   // The gap counter only needs to reach GapCycles-1 before it fires.
   localparam int GW        = (GapCycles > 1) ? $clog2(GapCycles) : 1;
   localparam int RW        = $clog2(FastThreshold + 1);

   localparam logic [GW-1:0] GAP_LAST  = GW'(GapCycles - 1);
   localparam logic [RW-1:0] RUN_ONE   = RW'(1);
   localparam logic [RW-1:0] RUN_FAST  = RW'(FastThreshold);
   localparam logic [W:0]    MIN_X     = (W + 1)'(MinValue);
   localparam logic [W:0]    MAX_X     = (W + 1)'(MaxValue);
   localparam logic [W:0]    STEP_ONE  = (W + 1)'(1);
   localparam logic [W:0]    STEP_FAST = (W + 1)'(FastStep);

   state_t          state, state_next;
   dir_t            dir, dir_next;
   logic [RW-1:0]   run, run_next;
   logic [GW-1:0]   gap, gap_next;

   logic            pulse;
   dir_t            pulse_dir;
   logic [W:0]      step;
   logic [W:0]      v_ext;
   logic [W:0]      bound;
   logic [W:0]      result;
   logic [W-1:0]    value_next;
   logic            changed_next;

   // Both strobes high at once is not a pulse.
   assign pulse     = iUp ^ iDown;
   assign pulse_dir = iUp ? DIR_UP : DIR_DOWN;

   // -------------------------------------------------------------------
   // FSM state register
   // -------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state <= IDLE;
         dir   <= DIR_UP;
         run   <= '0;
         gap   <= '0;
      end else begin
         state <= state_next;
         dir   <= dir_next;
         run   <= run_next;
         gap   <= gap_next;
      end
   end

   // -------------------------------------------------------------------
   // FSM next-state logic
   // -------------------------------------------------------------------
   always_comb begin
      state_next = state;
      dir_next   = dir;
      run_next   = run;
      gap_next   = gap;
      case (state)
         IDLE: begin
            if (pulse) begin
               state_next = SLOW;
               dir_next   = pulse_dir;
               run_next   = RUN_ONE;
               gap_next   = '0;
            end
         end
         SLOW, FAST: begin
            if (pulse) begin
               gap_next = '0;
               if (pulse_dir == dir) begin
                  // Run count saturates at the threshold once in FAST.
                  if (run < RUN_FAST) begin
                     run_next = run + RUN_ONE;
                  end
                  // The new run count reaches the threshold.
                  if (run >= RUN_FAST - RUN_ONE) begin
                     state_next = FAST;
                  end
               end else begin
                  state_next = SLOW;
                  dir_next   = pulse_dir;
                  run_next   = RUN_ONE;
               end
            end else if (gap == GAP_LAST) begin
               state_next = IDLE;
               run_next   = '0;
               gap_next   = '0;
            end else begin
               gap_next = gap + GW'(1);
            end
         end
         default: begin
            state_next = IDLE;
            run_next   = '0;
            gap_next   = '0;
         end
      endcase
   end

   // -------------------------------------------------------------------
   // FSM outputs: step size and the range-limited next value
   // -------------------------------------------------------------------
   always_comb begin
      // Only a same-direction pulse in FAST gets the large step; a reversal
      // restarts at a step of one.
      step   = (state == FAST && pulse_dir == dir) ? STEP_FAST : STEP_ONE;
      v_ext  = {1'b0, oValue};
      bound  = '0;
      result = v_ext;
      if (pulse_dir == DIR_UP) begin
         bound = v_ext + step;
         if (bound > MAX_X) begin
            result = (Wrap != 0) ? MIN_X + (bound - MAX_X - STEP_ONE) : MAX_X;
         end else begin
            result = bound;
         end
      end else begin
         // Compare against MIN+step instead of subtracting, so the
         // difference is never negative.
         bound = MIN_X + step;
         if (v_ext < bound) begin
            result = (Wrap != 0) ? MAX_X - (bound - v_ext - STEP_ONE) : MIN_X;
         end else begin
            result = v_ext - step;
         end
      end
      value_next   = pulse ? result[W-1:0] : oValue;
      changed_next = pulse && (result != v_ext);
   end

   // -------------------------------------------------------------------
   // Value and flag registers
   // -------------------------------------------------------------------
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         oValue   <= W'(MinValue);
         oChanged <= 1'b0;
         oAtMin   <= 1'b1;
         oAtMax   <= 1'b0;
      end else begin
         oValue   <= value_next;
         oChanged <= changed_next;
         oAtMin   <= (value_next == W'(MinValue));
         oAtMax   <= (value_next == W'(MaxValue));
      end
   end

   bin_to_bcd #(
      .W      (W),
      .Digits (Digits)
   ) u_bin_to_bcd (
      .bin (oValue),
      .bcd (oBcd)
   );

endmodule

// File: tb/tb_step_accumulator.sv
// ---------------------------------------------------------------------------
// tb_step_accumulator
//   Bench for step_accumulator with range 0..99, FastThreshold 4, FastStep 10
//   and a 10-cycle gap timeout. Two instances share all inputs: one
//   saturating, one wrapping.
// ---------------------------------------------------------------------------
module tb_step_accumulator;

   localparam int MINV = 0;
   localparam int MAXV = 99;
   localparam int FT   = 4;
   localparam int FS   = 10;
   localparam int GAP  = 10;

   logic       clk;
   logic       rst_n;
   logic       up;
   logic       down;

   logic [6:0] val_s, val_w;
   logic [7:0] bcd_s, bcd_w;
   logic       chg_s, chg_w, min_s, min_w, max_s, max_w;

   int n_checks = 0;
   int n_errors = 0;

   step_accumulator #(
      .ClockPeriod_ns (20), .GapTimeout_ns (200), .MinValue (MINV), .MaxValue (MAXV),
      .Wrap (0), .FastThreshold (FT), .FastStep (FS)
   ) dut_sat (
      .Clock (clk), .nReset (rst_n), .iUp (up), .iDown (down),
      .oValue (val_s), .oBcd (bcd_s), .oChanged (chg_s), .oAtMin (min_s), .oAtMax (max_s)
   );

   step_accumulator #(
      .ClockPeriod_ns (20), .GapTimeout_ns (200), .MinValue (MINV), .MaxValue (MAXV),
      .Wrap (1), .FastThreshold (FT), .FastStep (FS)
   ) dut_wrap (
      .Clock (clk), .nReset (rst_n), .iUp (up), .iDown (down),
      .oValue (val_w), .oBcd (bcd_w), .oChanged (chg_w), .oAtMin (min_w), .oAtMax (max_w)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // All tasks are entered and left at a falling edge.
   task automatic pulse(input logic u, input logic d);
      up   = u;
      down = d;
      @(negedge clk);
      up   = 1'b0;
      down = 1'b0;
   endtask

   task automatic gap(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      gap(2);
      rst_n = 1'b1;
   endtask

   task automatic ups(input int n);
      for (int i = 0; i < n; i++) pulse(1'b1, 1'b0);
   endtask

   task automatic downs(input int n);
      for (int i = 0; i < n; i++) pulse(1'b0, 1'b1);
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      return 8'(((v / 10) << 4) | (v % 10));
   endfunction

   // ---------------- behavioural reference model ----------------------
   int m_val [2];
   bit m_chg [2];
   int m_run;
   int m_idle;
   bit m_dir;

   function automatic int next_val(input int v, input bit is_up, input int s, input bit wrap);
      int range;
      int r;
      range = MAXV - MINV + 1;
      if (wrap) begin
         r = is_up ? (v - MINV + s) : (v - MINV - s);
         r = ((r % range) + range) % range;
         return r + MINV;
      end
      if (is_up) return (v + s > MAXV) ? MAXV : v + s;
      return (v - s < MINV) ? MINV : v - s;
   endfunction

   task automatic model_reset();
      m_val[0] = MINV; m_val[1] = MINV;
      m_chg[0] = 1'b0; m_chg[1] = 1'b0;
      m_run = 0; m_idle = 0; m_dir = 1'b1;
   endtask

   task automatic model_cycle(input bit rst, input bit u, input bit d);
      int  s;
      int  nv;
      bit  fresh;
      if (rst) begin
         model_reset();
         return;
      end
      if (u ^ d) begin
         fresh = (m_run == 0) || (m_idle >= GAP) || (u != m_dir);
         if (fresh) begin
            s     = 1;
            m_run = 1;
         end else begin
            s     = (m_run >= FT) ? FS : 1;
            m_run = (m_run + 1 > FT) ? FT : m_run + 1;
         end
         m_dir  = u;
         m_idle = 0;
         for (int k = 0; k < 2; k++) begin
            nv       = next_val(m_val[k], u, s, k == 1);
            m_chg[k] = (nv != m_val[k]);
            m_val[k] = nv;
         end
      end else begin
         if (m_idle < 1000) m_idle++;
         m_chg[0] = 1'b0;
         m_chg[1] = 1'b0;
      end
   endtask

   // ---------------- vector table -------------------------------------
   typedef struct {
      logic up;
      logic down;
      int   gap_after;
      int   exp_value;
      logic exp_changed;
   } vec_t;

   vec_t vecs[$];

   initial begin
      up    = 1'b0;
      down  = 1'b0;
      rst_n = 1'b0;

      // Accelerating run, reversal, timeout, and a both-high cycle.
      vecs.push_back('{1'b1, 1'b0, 2, 1, 1'b1});
      vecs.push_back('{1'b1, 1'b0, 2, 2, 1'b1});
      vecs.push_back('{1'b1, 1'b0, 2, 3, 1'b1});
      vecs.push_back('{1'b1, 1'b0, 2, 4, 1'b1});
      vecs.push_back('{1'b1, 1'b0, 2, 14, 1'b1});
      vecs.push_back('{1'b1, 1'b0, 2, 24, 1'b1});
      vecs.push_back('{1'b0, 1'b1, 12, 23, 1'b1});
      vecs.push_back('{1'b1, 1'b0, 1, 24, 1'b1});
      vecs.push_back('{1'b1, 1'b0, 1, 25, 1'b1});
      vecs.push_back('{1'b1, 1'b1, 1, 25, 1'b0});

      // Values while reset is held.
      @(negedge clk);
      check("rst_value", val_s, MINV);
      check("rst_changed", chg_s, 0);
      check("rst_at_min", min_s, 1);
      check("rst_at_max", max_s, 0);
      check("rst_bcd", bcd_s, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Scenario 1: three pulses two cycles apart; first pulse right after release.
      for (int k = 1; k <= 3; k++) begin
         pulse(1'b1, 1'b0);
         check("s1_value", val_s, k);
         check("s1_changed_hi", chg_s, 1);
         check("s1_at_min", min_s, 0);
         gap(1);
         check("s1_changed_lo", chg_s, 0);
      end
      check("s1_bcd", bcd_s, 8'h03);

      // Scenarios 2/3 from the table.
      do_reset();
      foreach (vecs[i]) begin
         up   = vecs[i].up;
         down = vecs[i].down;
         @(negedge clk);
         up   = 1'b0;
         down = 1'b0;
         check($sformatf("vec%0d_value", i), val_s, vecs[i].exp_value);
         check($sformatf("vec%0d_changed", i), chg_s, vecs[i].exp_changed);
         check($sformatf("vec%0d_wrap_value", i), val_w, vecs[i].exp_value);
         gap(vecs[i].gap_after);
      end

      // Gap boundary: 9 quiet cycles keep acceleration, 10 drop it.
      do_reset();
      ups(4);
      gap(9);
      pulse(1'b1, 1'b0);
      check("gap9_keeps_fast", val_s, 14);
      gap(10);
      pulse(1'b1, 1'b0);
      check("gap10_idle", val_s, 15);

      // Scenario 4: saturate at the top.
      do_reset();
      ups(13);
      check("s4_reach94", val_s, 94);
      pulse(1'b1, 1'b0);
      check("s4_sat_first", val_s, 99);
      check("s4_wrap_first", val_w, 4);
      pulse(1'b1, 1'b0);
      check("s4_sat_value", val_s, 99);
      check("s4_sat_changed", chg_s, 0);
      check("s4_sat_at_max", max_s, 1);
      check("s4_sat_bcd", bcd_s, 8'h99);
      check("s4_wrap_value", val_w, 14);

      // Scenario 4b: wrap from 95 while accelerated.
      do_reset();
      ups(13);
      downs(3);
      ups(4);
      check("s4b_at95", val_w, 95);
      pulse(1'b1, 1'b0);
      check("s4b_wrap_value", val_w, 5);
      check("s4b_wrap_changed", chg_w, 1);
      check("s4b_sat_value", val_s, 99);

      // Wrap down through the bottom from reset.
      do_reset();
      pulse(1'b0, 1'b1);
      check("wrap_down_value", val_w, 99);
      check("wrap_down_at_max", max_w, 1);
      check("sat_down_changed", chg_s, 0);
      check("sat_down_at_min", min_s, 1);

      // Scenario 5: both strobes high at 50.
      do_reset();
      ups(9);
      downs(4);
      check("s5_at50", val_s, 50);
      pulse(1'b1, 1'b1);
      check("s5_value", val_s, 50);
      check("s5_changed", chg_s, 0);

      // Scenario 5b: reset mid-run while accelerated at 40.
      do_reset();
      ups(8);
      downs(4);
      check("s5b_at40", val_s, 40);
      #2 rst_n = 1'b0;
      #1;
      check("s5b_async_value", val_s, 0);
      check("s5b_async_at_min", min_s, 1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      pulse(1'b1, 1'b0);
      check("s5b_after_value", val_s, 1);
      check("s5b_after_changed", chg_s, 1);

      // Randomised run against the reference model.
      do_reset();
      model_reset();
      begin
         int quiet;
         bit pref_up;
         quiet   = 0;
         pref_up = 1'b1;
         for (int i = 0; i < 1500; i++) begin
            bit do_rst;
            bit u;
            bit d;
            int r;
            do_rst = ($urandom_range(0, 199) == 0);
            u = 1'b0;
            d = 1'b0;
            if (quiet > 0) begin
               quiet--;
            end else begin
               r = $urandom_range(0, 9);
               if (r == 0) quiet = $urandom_range(5, 14);
               else if (r == 1) begin u = 1'b1; d = 1'b1; end
               else if (r <= 7) begin u = pref_up; d = !pref_up; end
               else if (r == 8) begin u = !pref_up; d = pref_up; end
               if ($urandom_range(0, 19) == 0) pref_up = !pref_up;
            end
            rst_n = !do_rst;
            up    = u;
            down  = d;
            @(negedge clk);
            model_cycle(do_rst, u, d);
            rst_n = 1'b1;
            up    = 1'b0;
            down  = 1'b0;
            check("rnd_sat_value", val_s, m_val[0]);
            check("rnd_sat_changed", chg_s, m_chg[0]);
            check("rnd_sat_at_min", min_s, m_val[0] == MINV);
            check("rnd_sat_at_max", max_s, m_val[0] == MAXV);
            check("rnd_sat_bcd", bcd_s, to_bcd(m_val[0]));
            check("rnd_wrap_value", val_w, m_val[1]);
            check("rnd_wrap_changed", chg_w, m_chg[1]);
            check("rnd_wrap_bcd", bcd_w, to_bcd(m_val[1]));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
